// File: rtl/addsub_digit_serial.sv
// addsub_digit_serial: digit-serial two's-complement add/sub with carry/overflow/zero flags; `ADDSUB_SAT_EN adds a saturating mode
module addsub_digit_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
`ifdef ADDSUB_SAT_EN
  input  logic             sat,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q, r_n, r_fin;
  logic [DIGIT-1:0] da, db;
  logic [DIGIT:0] sum;
  logic c, sat_on, accept, last, c_msb, ovf_n;
`ifdef ADDSUB_SAT_EN
  logic sat_q;
  assign sat_on = sat_q;
`else
  assign sat_on = 1'b0;
`endif
  assign accept = start && state != RUN;
  assign last   = cnt == CW'(N - 1);
  assign busy   = state == RUN;
  assign done   = state == DONE;
  assign da     = a_q[int'(cnt)*DIGIT +: DIGIT];
  assign db     = b_q[int'(cnt)*DIGIT +: DIGIT];
  assign sum    = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, c};
  // carry into the MSB recovered from the MSB's own sum bit
  assign c_msb  = sum[DIGIT-1] ^ da[DIGIT-1] ^ db[DIGIT-1];
  assign ovf_n  = c_msb ^ sum[DIGIT];
  assign r_fin  = (sat_on && ovf_n) ? {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}} : r_n;
  always_comb begin
    r_n = r;
    r_n[int'(cnt)*DIGIT +: DIGIT] = sum[DIGIT-1:0];
  end
  always_comb begin
    state_n = state;
    state_n = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      r    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
`ifdef ADDSUB_SAT_EN
      sat_q <= 1'b0;
`endif
    end else if (accept) begin
      a_q <= a;
      b_q <= b ^ {WIDTH{sub}};
      c   <= sub;
      cnt <= '0;
`ifdef ADDSUB_SAT_EN
      sat_q <= sat;
`endif
    end else if (state == RUN) begin
      r   <= last ? r_fin : r_n;
      c   <= sum[DIGIT];
      cnt <= cnt + 1'b1;
      if (last) begin
        cout <= sum[DIGIT];
        ovf  <= ovf_n;
        zero <= r_fin == '0;
      end
    end
  end
endmodule

// File: tb/tb_addsub_digit_serial.sv
// tb_addsub_digit_serial: scoreboard bench for the digit-serial add/sub (WIDTH=16, DIGIT=4)
module tb_addsub_digit_serial;
  localparam int N = 4;
  typedef struct {
    logic [15:0] r;
    logic cout, ovf, zero;
  } exp_t;
  exp_t q[$];
  logic clk = 0, rst = 1, start = 0, sub = 0, sat = 0;
  logic [15:0] a = 0, b = 0, r;
  logic busy, done, cout, ovf, zero;
  int cmp = 0, err = 0;

  addsub_digit_serial #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
`ifdef ADDSUB_SAT_EN
    .sat(sat),
`endif
    .a(a), .b(b), .busy(busy), .done(done), .r(r), .cout(cout), .ovf(ovf), .zero(zero));

  always #5 clk = ~clk;

  task automatic push_exp(input logic [15:0] x, input logic [15:0] y, input logic s, input logic st);
    exp_t e;
    logic [15:0] yb;
    logic [16:0] f;
    yb = s ? ~y : y;
    f = {1'b0, x} + {1'b0, yb} + {16'd0, s};
    e.r = f[15:0];
    e.cout = f[16];
    e.ovf = (x[15] == yb[15]) && (f[15] != x[15]);
`ifdef ADDSUB_SAT_EN
    if (st && e.ovf) e.r = x[15] ? 16'h8000 : 16'h7FFF;
`endif
    e.zero = e.r == 16'h0;
    q.push_back(e);
  endtask

  task automatic launch(input logic [15:0] x, input logic [15:0] y, input logic s, input logic st);
    @(negedge clk);
    a = x; b = y; sub = s; sat = st; start = 1;
    push_exp(x, y, s, st);
    @(negedge clk);
    start = 0;
    cmp++;
    if (busy !== 1'b1) begin err++; $display("FAIL busy_after_start: got %b want 1", busy); end
  endtask

  task automatic collect(input int lat);
    exp_t e;
    int k = 0;
    while (done !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    cmp++;
    if (k != lat) begin err++; $display("FAIL latency: got %0d want %0d", k, lat); end
    if (q.size() == 0) begin err++; $display("FAIL scoreboard_empty: got 0 want >0"); return; end
    e = q.pop_front();
    if (done !== 1'b1) return;
    cmp += 4;
    if (r !== e.r) begin err++; $display("FAIL r: got %h want %h", r, e.r); end
    if (cout !== e.cout) begin err++; $display("FAIL cout: got %b want %b", cout, e.cout); end
    if (ovf !== e.ovf) begin err++; $display("FAIL ovf: got %b want %b", ovf, e.ovf); end
    if (zero !== e.zero) begin err++; $display("FAIL zero: got %b want %b", zero, e.zero); end
  endtask

  task automatic test_reset;
    #1;
    cmp += 6;
    if (busy !== 0) begin err++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 0) begin err++; $display("FAIL reset_done: got %b want 0", done); end
    if (r !== 0) begin err++; $display("FAIL reset_r: got %h want 0", r); end
    if (cout !== 0) begin err++; $display("FAIL reset_cout: got %b want 0", cout); end
    if (ovf !== 0) begin err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    if (zero !== 0) begin err++; $display("FAIL reset_zero: got %b want 0", zero); end
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_add;
    logic [15:0] hold;
    launch(16'h1234, 16'h0FFF, 0, 0);
    collect(N);
    hold = r;
    @(negedge clk);
    cmp += 3;
    if (done !== 0) begin err++; $display("FAIL done_pulse: got %b want 0", done); end
    if (busy !== 0) begin err++; $display("FAIL idle_busy: got %b want 0", busy); end
    if (r !== 16'h2233 || hold !== 16'h2233) begin err++; $display("FAIL r_hold: got %h want 2233", r); end
    launch(16'hFFFF, 16'h0001, 0, 0);
    collect(N);
  endtask

  task automatic test_sub;
    launch(16'h0005, 16'h0007, 1, 0);
    collect(N);
    launch(16'hABCD, 16'hABCD, 1, 0);
    collect(N);
  endtask

  task automatic test_overflow;
    launch(16'h7FFF, 16'h0001, 0, 0);
    collect(N);
    launch(16'h8000, 16'h0001, 1, 0);
    collect(N);
`ifdef ADDSUB_SAT_EN
    launch(16'h7FFF, 16'h0001, 0, 1);
    collect(N);
    launch(16'h8000, 16'h0001, 1, 1);
    collect(N);
`endif
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      launch(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      collect(N);
    end
  endtask

  task automatic test_back_to_back;
    launch(16'h1111, 16'h2222, 0, 0);
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      start = 1'($urandom); a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    end
    collect(1);
    a = 16'h0001; b = 16'h0001; sub = 0; sat = 0; start = 1;
    push_exp(16'h0001, 16'h0001, 0, 0);
    @(negedge clk);
    start = 0;
    cmp++;
    if (busy !== 1'b1) begin err++; $display("FAIL b2b_busy: got %b want 1", busy); end
    collect(N);
  endtask

  task automatic test_mid_reset;
    bit saw = 0;
    launch(16'h1234, 16'h1111, 0, 0);
    @(negedge clk);
    rst = 1;
    #1;
    cmp += 6;
    if (busy !== 0) begin err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (done !== 0) begin err++; $display("FAIL midrst_done: got %b want 0", done); end
    if (r !== 0) begin err++; $display("FAIL midrst_r: got %h want 0", r); end
    if (cout !== 0) begin err++; $display("FAIL midrst_cout: got %b want 0", cout); end
    if (ovf !== 0) begin err++; $display("FAIL midrst_ovf: got %b want 0", ovf); end
    if (zero !== 0) begin err++; $display("FAIL midrst_zero: got %b want 0", zero); end
    void'(q.pop_front());
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); saw |= done; end
    cmp++;
    if (saw) begin err++; $display("FAIL midrst_no_done: got 1 want 0"); end
    launch(16'h0FF0, 16'h0010, 0, 0);
    collect(N);
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_overflow;
    test_back_to_back;
    test_random;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
